ram_tile_seq: RTL and testbench

RAM_TILE_SEQ -- requirements
Module: ram_tile_seq

---
 rtl/ram_tile_seq.sv | 128 ++++++++++++
 tb/tb_ram_tile_seq.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_tile_seq.sv
// Burst sequencer between a row-wide RAM tile and valid/ready streams.
// A command moves cmd_len rows starting at cmd_base, wrapping at the top of the address space.
module ram_tile_seq #(
    parameter int BIT_WIDTH     = 32,
    parameter int RAM_WIDTH     = 4,
    parameter int RAM_ADDR_BITS = 10,
    parameter int LEN_BITS      = 11
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic                           cmd_write,
    input  logic [RAM_ADDR_BITS-1:0]       cmd_base,
    input  logic [LEN_BITS-1:0]            cmd_len,
    input  logic                           wr_valid,
    output logic                           wr_ready,
    input  logic [BIT_WIDTH*RAM_WIDTH-1:0] wr_data,
    output logic                           rd_valid,
    input  logic                           rd_ready,
    output logic [BIT_WIDTH*RAM_WIDTH-1:0] rd_data,
    output logic                           busy,
    output logic                           done,
    output logic [RAM_ADDR_BITS-1:0]       ram_rdaddress,
    output logic [RAM_ADDR_BITS-1:0]       ram_wraddress,
    output logic                           ram_wren,
    output logic [BIT_WIDTH*RAM_WIDTH-1:0] ram_data,
    input  logic [BIT_WIDTH*RAM_WIDTH-1:0] ram_q
);

    localparam int DW = BIT_WIDTH * RAM_WIDTH;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]               state_q, state_d;
    logic [RAM_ADDR_BITS-1:0] ptr_q, ptr_d;
    logic [LEN_BITS-1:0]      cnt_q, cnt_d;
    logic                     rd_valid_q, rd_valid_d;
    logic [DW-1:0]            rd_data_q, rd_data_d;
    logic                     fetch;

    // The output register refills whenever it is empty or being drained this cycle.
    assign fetch = (state_q == READ) && (!rd_valid_q || rd_ready) && (cnt_q != '0);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    ptr_d = cmd_base;
                    cnt_d = cmd_len;
                    if (cmd_len == '0) begin
                        state_d = DONE;
                    end else if (cmd_write) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            WRITE: begin
                if (wr_valid) begin
                    ptr_d = ptr_q + RAM_ADDR_BITS'(1);
                    cnt_d = cnt_q - LEN_BITS'(1);
                    if (cnt_q == LEN_BITS'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            READ: begin
                if (rd_valid_q && rd_ready) begin
                    rd_valid_d = 1'b0;
                    if (cnt_q == '0) begin
                        state_d = DONE;
                    end
                end
                if (fetch) begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = ram_q;
                    ptr_d      = ptr_q + RAM_ADDR_BITS'(1);
                    cnt_d      = cnt_q - LEN_BITS'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            cnt_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Write data passes straight through so a beat lands in the RAM in its handshake cycle.
    assign cmd_ready     = (state_q == IDLE);
    assign wr_ready      = (state_q == WRITE);
    assign ram_wren      = wr_ready && wr_valid;
    assign ram_data      = wr_data;
    assign ram_rdaddress = ptr_q;
    assign ram_wraddress = ptr_q;
    assign rd_valid      = rd_valid_q;
    assign rd_data       = rd_data_q;
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);

endmodule

// File: tb/tb_ram_tile_seq.sv
// Scoreboard bench for ram_tile_seq: a reference memory predicts every RAM write and
// every read-stream row; a negedge monitor pops and compares whenever the DUT presents one.
module tb_ram_tile_seq;

    localparam int BW    = 32;
    localparam int RW    = 4;
    localparam int AB    = 10;
    localparam int LB    = 11;
    localparam int DW    = BW * RW;
    localparam int DEPTH = 1 << AB;

    logic          clock, reset_n;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AB-1:0] cmd_base;
    logic [LB-1:0] cmd_len;
    logic          wr_valid, wr_ready;
    logic [DW-1:0] wr_data;
    logic          rd_valid, rd_ready;
    logic [DW-1:0] rd_data;
    logic          busy, done;
    logic [AB-1:0] ram_rdaddress, ram_wraddress;
    logic          ram_wren;
    logic [DW-1:0] ram_data, ram_q;

    ram_tile_seq #(
        .BIT_WIDTH(BW), .RAM_WIDTH(RW), .RAM_ADDR_BITS(AB), .LEN_BITS(LB)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_base(cmd_base), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .busy(busy), .done(done),
        .ram_rdaddress(ram_rdaddress), .ram_wraddress(ram_wraddress),
        .ram_wren(ram_wren), .ram_data(ram_data), .ram_q(ram_q)
    );

    // Bench-side RAM tile (environment) and the reference contents it should hold.
    logic [DW-1:0] mem     [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];
    assign ram_q = mem[ram_rdaddress];

    logic [AB-1:0] exp_wa[$];
    logic [DW-1:0] exp_wd[$];
    logic [DW-1:0] exp_rd[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int first_valid_cyc = -1;
    int done_seen = 0;
    bit over;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial forever begin
        @(posedge clock);
        cyc++;
        if (ram_wren) mem[ram_wraddress] = ram_data;
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] rnd_row();
        logic [DW-1:0] r;
        for (int j = 0; j < RW; j++) r[j*BW +: BW] = BW'($urandom);
        return r;
    endfunction

    // Monitor: pops the scoreboard on every write beat and read handshake.
    initial begin
        bit            prev_hold;
        logic [DW-1:0] prev_data;
        prev_hold = 1'b0;
        prev_data = '0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                prev_hold = 1'b0;
            end else begin
                if (ram_wren) begin
                    if (exp_wa.size() == 0) begin
                        chki("unexpected_write", int'(ram_wraddress), -1);
                    end else begin
                        chki("wr_addr", int'(ram_wraddress), int'(exp_wa.pop_front()));
                        chk("wr_data", ram_data, exp_wd.pop_front());
                    end
                end
                if (rd_valid && rd_ready) begin
                    if (exp_rd.size() == 0) chki("unexpected_read_row", int'(ram_rdaddress), -1);
                    else chk("rd_data", rd_data, exp_rd.pop_front());
                end
                if (prev_hold) begin
                    chki("rd_hold_valid", int'(rd_valid), 1);
                    chk("rd_hold_data", rd_data, prev_data);
                end
                prev_hold = rd_valid && !rd_ready;
                prev_data = rd_data;
                if (rd_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
                if (done) done_seen++;
            end
        end
    end

    task automatic wait_done(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (done) begin
                at = cyc;
                chki("busy_in_done", int'(busy), 1);
                break;
            end
        end
        if (at < 0) chki("done_timeout", 0, 1);
        over = 1'b1;
    endtask

    // mode 0: random stream handshakes, 1: always valid/ready, 2: read stalls 5 cycles at first row
    task automatic drive(input bit wr, input int len, input int mode, input int beats,
                         input logic [DW-1:0] wq[$]);
        if (wr) begin
            wr_valid = (beats < len) && (mode != 0 || $urandom_range(0, 3) != 0);
            wr_data  = (beats < len) ? wq[beats] : rnd_row();
        end else if (mode == 2) begin
            rd_ready = (first_valid_cyc >= 0) && (cyc >= first_valid_cyc + 5);
        end else begin
            rd_ready = (mode == 1) || ($urandom_range(0, 2) != 0);
        end
    endtask

    task automatic run_cmd(input bit wr, input logic [AB-1:0] base, input int len, input int mode);
        logic [DW-1:0] wq[$];
        logic [AB-1:0] a;
        logic [DW-1:0] d;
        int issue, at, beats, exp_at;
        for (int i = 0; i < len; i++) begin
            a = base + AB'(i);
            if (wr) begin
                d = rnd_row();
                wq.push_back(d);
                ref_mem[a] = d;
                exp_wa.push_back(a);
                exp_wd.push_back(d);
            end else begin
                exp_rd.push_back(ref_mem[a]);
            end
        end
        beats = 0;
        over = 1'b0;
        first_valid_cyc = -1;
        @(posedge clock);
        #1;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_base  = base;
        cmd_len   = LB'(len);
        issue     = cyc;
        drive(wr, len, mode, beats, wq);
        fork
            begin
                while (!over) begin
                    @(negedge clock);
                    if (wr_valid && wr_ready) beats++;
                    @(posedge clock);
                    #1;
                    cmd_valid = 1'b0;
                    drive(wr, len, mode, beats, wq);
                end
            end
            wait_done(len * 8 + 40, at);
        join
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        if (len == 0) exp_at = issue + 1;
        else if (wr) exp_at = issue + len + 1;
        else if (mode == 2) exp_at = issue + len + 7;
        else exp_at = issue + len + 2;
        if (mode != 0 || len == 0) chki("done_cycle", at, exp_at);
        if (!wr) chki("first_valid_cycle", first_valid_cyc, (len == 0) ? -1 : issue + 2);
        @(negedge clock);
        chki("done_one_cycle", int'(done), 0);
        chki("idle_cmd_ready", int'(cmd_ready), 1);
        chki("idle_busy", int'(busy), 0);
        chki("scoreboard_drained", exp_wa.size() + exp_rd.size(), 0);
    endtask

    task automatic reset_mid_write();
        logic [AB-1:0] a;
        logic [DW-1:0] d0;
        int seen;
        a  = AB'($urandom);
        d0 = rnd_row();
        ref_mem[a] = d0;
        exp_wa.push_back(a);
        exp_wd.push_back(d0);
        seen = done_seen;
        @(posedge clock);
        #1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_base = a; cmd_len = LB'(8);
        wr_valid  = 1'b1; wr_data = d0;
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        @(posedge clock);
        #1;
        wr_data = rnd_row();
        reset_n = 1'b0;
        @(negedge clock);
        chki("rst_wren", int'(ram_wren), 0);
        chki("rst_busy", int'(busy), 0);
        chki("rst_done", int'(done), 0);
        chki("rst_wr_ready", int'(wr_ready), 0);
        wr_valid = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        chki("rst_no_done", done_seen, seen);
        chki("rst_write_count", exp_wa.size(), 0);
        run_cmd(1'b0, a, 2, 1);
    endtask

    initial begin
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_base = '0; cmd_len = '0;
        wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chki("reset_cmd_ready", int'(cmd_ready), 1);
        chki("reset_rd_valid", int'(rd_valid), 0);
        chki("reset_done", int'(done), 0);
        chki("reset_busy", int'(busy), 0);
        chki("reset_wren", int'(ram_wren), 0);
        chki("reset_ptr", int'(ram_rdaddress), 0);
        chk("reset_rd_data", rd_data, '0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        run_cmd(1'b1, AB'(0), DEPTH, 1);          // fill the whole tile
        run_cmd(1'b1, AB'('h010), 4, 1);
        run_cmd(1'b0, AB'('h010), 4, 1);
        run_cmd(1'b0, AB'($urandom), 3, 2);        // stalled first row
        run_cmd(1'b1, AB'('h3FE), 4, 1);           // wrap on write
        run_cmd(1'b0, AB'('h3FE), 4, 1);
        run_cmd(1'b1, AB'('h123), 0, 1);
        run_cmd(1'b0, AB'('h123), 0, 1);
        reset_mid_write();
        run_cmd(1'b0, AB'('h3F0), DEPTH + 6, 1);   // longer than the tile
        run_cmd(1'b1, AB'('h200), DEPTH + 3, 0);
        for (int n = 0; n < 40; n++) begin
            run_cmd(1'($urandom_range(0, 1)), AB'($urandom), $urandom_range(0, 9),
                    $urandom_range(0, 1));
        end
        run_cmd(1'b0, AB'('h200), 8, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
